multicycle_controller: RTL and testbench

Multi-cycle control FSM for the MP3 MIPS-subset CPU. Sequences one shared ALU, one unified instruction/data memory port, the register file and the PC through fetch, decode, execute, memory and write-back phases. Decodes the latched instruction register each cycle and drives every datapath strobe and mux select. Also counts retired instructions and traps on unsupported opcodes.

---
 rtl/multicycle_controller.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM for a multi-cycle MIPS-subset CPU. One shared ALU, one unified
//   memory port, register file and PC are sequenced through FETCH, DECODE,
//   EXEC, MEM and WB. All strobes and selects are combinational from the
//   current state and the latched instruction register. Retired instructions
//   are counted; an unsupported opcode parks the FSM in TRAP until reset.
//
//   Optional feature: define MEM_WAIT_EN to add the mem_ready handshake, which
//   holds FETCH and MEM until memory answers. Without it memory is single-cycle.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   instruction  instruction register contents
//   zero         ALU zero flag (used by beq in EXEC)
//   mem_ready    memory handshake (MEM_WAIT_EN only)
//   ir_wr        latch memory data into the instruction register
//   pc_wr        load PC
//   pc_src       00 PC+4, 01 branch target, 10 jump target, 11 rs
//   alu_src_b    0 rt, 1 sext(imm16)
//   alu_op       000 add, 001 subtract
//   mem_rd       memory read strobe
//   dm_wr        data memory write strobe
//   reg_wr       register-file write enable
//   reg_dst      00 rt, 01 rd, 10 r31
//   wb_sel       00 ALU, 01 memory data, 10 PC (link)
//   retire       pulse in the final cycle of each instruction
//   instr_count  retired-instruction count, wraps silently
//   trap         illegal-instruction flag, held until reset
//   state        current FSM state
//
// state | meaning
// FETCH  (0) | read instruction, latch IR, PC <= PC+4
// DECODE (1) | classify opcode; jumps complete here
// EXEC   (2) | ALU operation; beq completes here
// MEM    (3) | data access for lw/sw; sw completes here
// WB     (4) | register write-back
// TRAP   (7) | unsupported opcode, all strobes off until reset

module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instruction,
  input  logic             zero,
`ifdef MEM_WAIT_EN
  input  logic             mem_ready,
`endif
  output logic             ir_wr,
  output logic             pc_wr,
  output logic [1:0]       pc_src,
  output logic             alu_src_b,
  output logic [2:0]       alu_op,
  output logic             mem_rd,
  output logic             dm_wr,
  output logic             reg_wr,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic             trap,
  output logic [2:0]       state
);

`ifndef MEM_WAIT_EN
  logic mem_ready;
  assign mem_ready = 1'b1;
`endif

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t cur, nxt;

  logic [5:0] opcode, funct;
  logic is_add, is_addi, is_lw, is_sw, is_beq, is_j, is_jal, is_jr;
  logic unused_instr;

  assign opcode  = instruction[31:26];
  assign funct   = instruction[5:0];
  assign is_add  = (opcode == 6'b000000) && (funct == 6'b100000 || funct == 6'b100001);
  assign is_jr   = (opcode == 6'b000000) && (funct == 6'b001000);
  assign is_addi = (opcode == 6'b001000) || (opcode == 6'b001001);
  assign is_lw   = (opcode == 6'b100011);
  assign is_sw   = (opcode == 6'b101011);
  assign is_beq  = (opcode == 6'b000100);
  assign is_j    = (opcode == 6'b000010);
  assign is_jal  = (opcode == 6'b000011);
  assign unused_instr = ^instruction[25:6];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur         <= S_FETCH;
      instr_count <= '0;
    end else begin
      cur <= nxt;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    nxt       = cur;
    ir_wr     = 1'b0;
    pc_wr     = 1'b0;
    pc_src    = 2'b00;
    alu_src_b = 1'b0;
    alu_op    = 3'b000;
    mem_rd    = 1'b0;
    dm_wr     = 1'b0;
    reg_wr    = 1'b0;
    reg_dst   = 2'b00;
    wb_sel    = 2'b00;
    retire    = 1'b0;
    unique case (cur)
      S_FETCH: begin
        mem_rd = 1'b1;
        ir_wr  = mem_ready;
        pc_wr  = mem_ready;
        if (mem_ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        if (is_add || is_addi || is_lw || is_sw || is_beq) begin
          nxt = S_EXEC;
        end else if (is_j || is_jal) begin
          pc_wr  = 1'b1;
          pc_src = 2'b10;
          retire = 1'b1;
          nxt    = S_FETCH;
          if (is_jal) begin
            // PC was already advanced in FETCH, so it is the link value
            reg_wr  = 1'b1;
            reg_dst = 2'b10;
            wb_sel  = 2'b10;
          end
        end else if (is_jr) begin
          pc_wr  = 1'b1;
          pc_src = 2'b11;
          retire = 1'b1;
          nxt    = S_FETCH;
        end else begin
          nxt = S_TRAP;
        end
      end
      S_EXEC: begin
        alu_src_b = is_addi || is_lw || is_sw;
        if (is_beq) begin
          alu_op = 3'b001;
          pc_wr  = zero;
          pc_src = 2'b01;
          retire = 1'b1;
          nxt    = S_FETCH;
        end else if (is_lw || is_sw) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        if (is_sw) begin
          dm_wr  = 1'b1;
          retire = mem_ready;
          if (mem_ready) nxt = S_FETCH;
        end else begin
          mem_rd = 1'b1;
          if (mem_ready) nxt = S_WB;
        end
      end
      S_WB: begin
        reg_wr  = 1'b1;
        reg_dst = is_add ? 2'b01 : 2'b00;
        wb_sel  = is_lw ? 2'b01 : 2'b00;
        retire  = 1'b1;
        nxt     = S_FETCH;
      end
      S_TRAP: nxt = S_TRAP;
      default: nxt = S_FETCH;
    endcase

    // Reset cycle: nothing may write state outside the controller
    if (!rst_n) begin
      ir_wr     = 1'b0;
      pc_wr     = 1'b0;
      pc_src    = 2'b00;
      alu_src_b = 1'b0;
      alu_op    = 3'b000;
      mem_rd    = 1'b0;
      dm_wr     = 1'b0;
      reg_wr    = 1'b0;
      reg_dst   = 2'b00;
      wb_sel    = 2'b00;
      retire    = 1'b0;
    end
  end

  assign trap  = (cur == S_TRAP);
  assign state = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller. The reference describes each
// instruction class by its phase list and the strobes each phase must show.
module tb_multicycle_controller;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   instruction;
  logic          zero;
  logic          mem_ready;
  logic          ir_wr, pc_wr, alu_src_b, mem_rd, dm_wr, reg_wr, retire, trap;
  logic [1:0]    pc_src, reg_dst, wb_sel;
  logic [2:0]    alu_op, state;
  logic [CW-1:0] instr_count;

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .zero(zero),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .mem_rd(mem_rd), .dm_wr(dm_wr), .reg_wr(reg_wr),
    .reg_dst(reg_dst), .wb_sel(wb_sel), .retire(retire),
    .instr_count(instr_count), .trap(trap), .state(state)
  );

  typedef enum int {C_ADD, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR, C_ILL} cls_t;
  localparam logic [2:0] P_F = 3'd0, P_D = 3'd1, P_E = 3'd2, P_M = 3'd3,
                         P_W = 3'd4, P_T = 3'd7;

  typedef struct packed {
    logic [2:0] st;
    logic       ir_wr, pc_wr;
    logic [1:0] pc_src;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic       mem_rd, dm_wr, reg_wr;
    logic [1:0] reg_dst, wb_sel;
    logic       retire, trap;
  } outs_t;

  outs_t obs;
  assign obs = {state, ir_wr, pc_wr, pc_src, alu_src_b, alu_op, mem_rd, dm_wr,
                reg_wr, reg_dst, wb_sel, retire, trap};

  int tests = 0;
  int fails = 0;
  logic [CW-1:0] mcount;

  function automatic outs_t model(input logic [2:0] ph, input cls_t c,
                                  input logic z, input logic rdy);
    outs_t o;
    o = '0;
    o.st = ph;
    case (ph)
      P_F: begin o.mem_rd = 1; o.ir_wr = rdy; o.pc_wr = rdy; end
      P_D: begin
        if (c == C_J || c == C_JAL) begin o.pc_wr = 1; o.pc_src = 2; o.retire = 1; end
        if (c == C_JAL) begin o.reg_wr = 1; o.reg_dst = 2; o.wb_sel = 2; end
        if (c == C_JR) begin o.pc_wr = 1; o.pc_src = 3; o.retire = 1; end
      end
      P_E: begin
        o.alu_src_b = (c == C_ADDI || c == C_LW || c == C_SW);
        if (c == C_BEQ) begin o.alu_op = 1; o.pc_wr = z; o.pc_src = 1; o.retire = 1; end
      end
      P_M: begin
        if (c == C_LW) o.mem_rd = 1;
        if (c == C_SW) begin o.dm_wr = 1; o.retire = rdy; end
      end
      P_W: begin
        o.reg_wr = 1;
        o.reg_dst = (c == C_ADD) ? 2'd1 : 2'd0;
        o.wb_sel = (c == C_LW) ? 2'd1 : 2'd0;
        o.retire = 1;
      end
      default: o.trap = 1;
    endcase
    return o;
  endfunction

  function automatic logic [31:0] gen(input cls_t c);
    logic [31:0] r;
    logic [5:0]  op;
    logic [5:0]  fn;
    r = $urandom;
    case (c)
      C_ADD:  begin r[31:26] = 6'h00; r[5:0] = ($urandom_range(0, 1) != 0) ? 6'h21 : 6'h20; end
      C_ADDI: r[31:26] = ($urandom_range(0, 1) != 0) ? 6'h09 : 6'h08;
      C_LW:   r[31:26] = 6'h23;
      C_SW:   r[31:26] = 6'h2B;
      C_BEQ:  r[31:26] = 6'h04;
      C_J:    r[31:26] = 6'h02;
      C_JAL:  r[31:26] = 6'h03;
      C_JR:   begin r[31:26] = 6'h00; r[5:0] = 6'h08; end
      default: begin
        op = 6'($urandom_range(0, 63));
        while (op inside {6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h23, 6'h2B})
          op = 6'($urandom_range(0, 63));
        r[31:26] = op;
        if (op == 6'h00) begin
          fn = 6'($urandom_range(0, 63));
          while (fn inside {6'h20, 6'h21, 6'h08}) fn = 6'($urandom_range(0, 63));
          r[5:0] = fn;
        end
      end
    endcase
    return r;
  endfunction

  task automatic cycle(input outs_t e, input string tag);
    @(negedge clk);
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s outputs observed=%h expected=%h", tag, obs, e);
    end
    tests++;
    assert (instr_count === mcount) else begin
      fails++;
      $error("FAIL %s instr_count observed=%0d expected=%0d", tag, instr_count, mcount);
    end
    if (e.retire) mcount++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    assert ({ir_wr, pc_wr, pc_src, alu_src_b, alu_op, mem_rd, dm_wr, reg_wr,
             reg_dst, wb_sel, retire} === 17'd0) else begin
      fails++;
      $error("FAIL %s reset strobes observed=%b expected=0", tag,
             {ir_wr, pc_wr, pc_src, alu_src_b, alu_op, mem_rd, dm_wr, reg_wr,
              reg_dst, wb_sel, retire});
    end
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mcount = '0;
  endtask

  // zmode: 0/1 forces the ALU zero flag, anything else randomizes it
  task automatic run_instr(input logic [31:0] ins, input cls_t c, input int zmode,
                           input string tag);
    logic [2:0] ph[$];
    int holds;
    instruction = ins;
    case (c)
      C_J, C_JAL, C_JR, C_ILL: ph = '{P_F, P_D};
      C_BEQ:                   ph = '{P_F, P_D, P_E};
      C_LW:                    ph = '{P_F, P_D, P_E, P_M, P_W};
      C_SW:                    ph = '{P_F, P_D, P_E, P_M};
      default:                 ph = '{P_F, P_D, P_E, P_W};
    endcase
    if (c == C_ILL) ph.push_back(P_T);
    foreach (ph[i]) begin
      holds = 0;
`ifdef MEM_WAIT_EN
      if (ph[i] == P_F || ph[i] == P_M) holds = $urandom_range(0, 2);
`endif
      for (int k = 0; k < holds; k++) begin
        mem_ready = 1'b0;
        zero = 1'($urandom_range(0, 1));
        cycle(model(ph[i], c, zero, 1'b0), tag);
      end
      mem_ready = 1'b1;
      zero = (zmode == 0 || zmode == 1) ? 1'(zmode) : 1'($urandom_range(0, 1));
      cycle(model(ph[i], c, zero, 1'b1), tag);
    end
  endtask

  initial begin
    cls_t c;
    rst_n = 1'b0;
    instruction = 32'h0;
    zero = 1'b0;
    mem_ready = 1'b1;
    mcount = '0;

    do_reset("reset0");
    run_instr(32'h03E08820, C_ADD,  -1, "add");
    run_instr(32'h8C080004, C_LW,   -1, "lw");
    run_instr(32'h10000001, C_BEQ,   1, "beq_taken");
    run_instr(32'h10000001, C_BEQ,   0, "beq_not_taken");
    run_instr(32'h0C000010, C_JAL,  -1, "jal");

    // illegal opcode: trap holds until reset
    run_instr(32'hFC000000, C_ILL,  -1, "illegal");
    for (int i = 0; i < 10; i++) cycle(model(P_T, C_ILL, 1'b0, 1'b1), "trap_hold");
    do_reset("trap_reset");
    run_instr(32'h03E08820, C_ADD,  -1, "add_after_trap");

    // reset in the WB cycle of an add: no write, no count
    instruction = 32'h03E08820;
    cycle(model(P_F, C_ADD, 1'b0, 1'b1), "abort_f");
    cycle(model(P_D, C_ADD, 1'b0, 1'b1), "abort_d");
    cycle(model(P_E, C_ADD, 1'b0, 1'b1), "abort_e");
    do_reset("abort_wb");
    run_instr(32'h8C080004, C_LW,   -1, "lw_after_abort");

`ifdef MEM_WAIT_EN
    // sw with three wait cycles in MEM
    instruction = 32'hAC080000;
    mem_ready = 1'b1;
    cycle(model(P_F, C_SW, 1'b0, 1'b1), "sw_wait_f");
    cycle(model(P_D, C_SW, 1'b0, 1'b1), "sw_wait_d");
    cycle(model(P_E, C_SW, 1'b0, 1'b1), "sw_wait_e");
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle(model(P_M, C_SW, 1'b0, 1'b0), "sw_wait_hold");
    mem_ready = 1'b1;
    cycle(model(P_M, C_SW, 1'b0, 1'b1), "sw_wait_ready");
    // reset during a MEM hold
    cycle(model(P_F, C_SW, 1'b0, 1'b1), "sw_abort_f");
    cycle(model(P_D, C_SW, 1'b0, 1'b1), "sw_abort_d");
    cycle(model(P_E, C_SW, 1'b0, 1'b1), "sw_abort_e");
    mem_ready = 1'b0;
    cycle(model(P_M, C_SW, 1'b0, 1'b0), "sw_abort_hold");
    do_reset("sw_abort_reset");
    mem_ready = 1'b1;
`endif

    // random legal instruction stream; count wraps at 2^CW
    for (int n = 0; n < 60; n++) begin
      c = cls_t'($urandom_range(0, 7));
      run_instr(gen(c), c, -1, "random");
    end

    // random illegal encodings
    for (int n = 0; n < 4; n++) begin
      run_instr(gen(C_ILL), C_ILL, -1, "random_illegal");
      cycle(model(P_T, C_ILL, 1'b0, 1'b1), "random_trap_hold");
      do_reset("random_trap_reset");
      c = cls_t'($urandom_range(0, 7));
      run_instr(gen(c), c, -1, "random_after_trap");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout waiting for stimulus to complete");
    $fatal(1, "timeout");
  end
endmodule
